// File: rtl/perceptron_update_ctrl.sv
// Sole writer of the perceptron weight table: zero sweep after reset, then in-order
// read-modify-write updates (saturating +/-1 per weight) drained from a small request FIFO.
module perceptron_update_ctrl #(
  parameter int ENTRIES    = 64,
  parameter int IDX_W      = 6,
  parameter int GHR_W      = 12,
  parameter int WEIGHT_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic [GHR_W-1:0]          upd_ghr,
  input  logic                      upd_dir,
  input  logic                      upd_train,
  output logic                      tbl_rd_en,
  output logic [IDX_W-1:0]          tbl_rd_addr,
  input  logic [GHR_W*WEIGHT_W-1:0] tbl_rd_data,
  output logic                      tbl_wr_en,
  output logic [IDX_W-1:0]          tbl_wr_addr,
  output logic [GHR_W*WEIGHT_W-1:0] tbl_wr_data,
  output logic                      init_done,
  output logic                      busy,
  output logic [15:0]               skip_count
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = GHR_W * WEIGHT_W;
  localparam logic [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic [IDX_W:0]      SWEEP_END = (IDX_W+1)'(ENTRIES);
  localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_CAPT, S_WRITE} state_t;
  state_t state;

  logic [IDX_W:0]     sweep_idx;
  logic [IDX_W-1:0]   fifo_idx [FIFO_DEPTH];
  logic [GHR_W-1:0]   fifo_ghr [FIFO_DEPTH];
  logic               fifo_dir [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               accept, push, pop;
  logic [IDX_W-1:0]   head_idx;
  logic [GHR_W-1:0]   head_ghr;
  logic               head_dir;
  logic [DATA_W-1:0]  new_w;
  logic [WEIGHT_W-1:0] w_cur, w_nxt;

  // Handshake: a request is taken on any rising edge where upd_valid and upd_ready are both high;
  // upd_ready depends only on the registered count, so a same-edge pop never frees a full FIFO.
  assign upd_ready = (count != CNT_FULL);
  assign accept    = upd_valid & upd_ready;
  assign push      = accept & upd_train;
  assign pop       = (state == S_WRITE);
  assign busy      = (state != S_IDLE) || (count != '0);

  assign head_idx = fifo_idx[rd_ptr];
  assign head_ghr = fifo_ghr[rd_ptr];
  assign head_dir = fifo_dir[rd_ptr];

  always_comb begin
    new_w = '0;
    w_cur = '0;
    w_nxt = '0;
    for (int i = 0; i < GHR_W; i++) begin
      w_cur = tbl_rd_data[i*WEIGHT_W +: WEIGHT_W];
      if (head_dir == head_ghr[i]) w_nxt = (w_cur == W_MAX) ? w_cur : w_cur + W_ONE;
      else                         w_nxt = (w_cur == W_MIN) ? w_cur : w_cur - W_ONE;
      new_w[i*WEIGHT_W +: WEIGHT_W] = w_nxt;
    end
  end

  // Payload storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= upd_idx;
      fifo_ghr[wr_ptr] <= upd_ghr;
      fifo_dir[wr_ptr] <= upd_dir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      skip_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && !upd_train) skip_count <= skip_count + 16'd1;
    end
  end

  // Table-port registers are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      sweep_idx   <= '0;
      init_done   <= 1'b0;
      tbl_rd_en   <= 1'b0;
      tbl_rd_addr <= '0;
      tbl_wr_en   <= 1'b0;
      tbl_wr_addr <= '0;
      tbl_wr_data <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (sweep_idx == SWEEP_END) begin
            tbl_wr_en <= 1'b0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tbl_wr_en   <= 1'b1;
            tbl_wr_addr <= sweep_idx[IDX_W-1:0];
            tbl_wr_data <= '0;
            sweep_idx   <= sweep_idx + (IDX_W+1)'(1);
          end
        end
        S_IDLE: begin
          tbl_wr_en <= 1'b0;
          tbl_rd_en <= 1'b0;
          if (count != '0) begin
            tbl_rd_en   <= 1'b1;
            tbl_rd_addr <= head_idx;
            state       <= S_READ;
          end
        end
        S_READ: begin
          tbl_rd_en <= 1'b0;
          state     <= S_CAPT;
        end
        S_CAPT: begin
          tbl_wr_en   <= 1'b1;
          tbl_wr_addr <= head_idx;
          tbl_wr_data <= new_w;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          tbl_wr_en <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_update_ctrl.sv
// Directed bench for perceptron_update_ctrl: table RAM model, expected-write scoreboard
// with a separate monitor, and direct checks of sweep, handshake, skip and reset behaviour.
module tb_perceptron_update_ctrl;
  localparam int IDX_W = 6;
  localparam int DW    = 96;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic [11:0]       upd_ghr = '0;
  logic              upd_dir = 1'b0;
  logic              upd_train = 1'b0;
  logic              tbl_rd_en;
  logic [IDX_W-1:0]  tbl_rd_addr;
  logic [DW-1:0]     tbl_rd_data = '0;
  logic              tbl_wr_en;
  logic [IDX_W-1:0]  tbl_wr_addr;
  logic [DW-1:0]     tbl_wr_data;
  logic              init_done;
  logic              busy;
  logic [15:0]       skip_count;

  logic [DW-1:0]     mem [64];
  logic              poke_en = 1'b0;
  logic [IDX_W-1:0]  poke_addr = '0;
  logic [DW-1:0]     poke_data = '0;

  logic [IDX_W+DW-1:0] exp_q[$];
  logic [IDX_W-1:0]    rd_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  perceptron_update_ctrl dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_ghr(upd_ghr), .upd_dir(upd_dir), .upd_train(upd_train),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .init_done(init_done), .busy(busy), .skip_count(skip_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // table RAM: one-cycle read latency, plus a backdoor preload port
  always @(posedge clk) begin
    if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic send(input logic [IDX_W-1:0] idx, input logic [11:0] ghr, input logic dir,
                      input logic train, input logic [DW-1:0] exp_data);
    int n;
    @(negedge clk);
    upd_valid = 1'b1; upd_idx = idx; upd_ghr = ghr; upd_dir = dir; upd_train = train;
    if (train) begin
      exp_q.push_back({idx, exp_data});
      rd_q.push_back(idx);
    end
    n = 0;
    while (!upd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", upd_ready, 1'b1);
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic poke(input logic [IDX_W-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  // scoreboard monitor: compares every post-init read address and write
  always @(negedge clk) begin
    if (init_done && tbl_rd_en) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got read of addr %0d, expected no read", tbl_rd_addr);
      end else chk("rd_addr", tbl_rd_addr, rd_q.pop_front());
    end
    if (init_done && tbl_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got write of addr %0d, expected no write", tbl_wr_addr);
      end else chk("wr_addr_data", {tbl_wr_addr, tbl_wr_data}, exp_q.pop_front());
    end
  end

  initial begin
    int bad;
    int n;
    reset = 1'b0;
    #1 reset = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_wr_en", tbl_wr_en, 1'b0);
    chk("rst_rd_en", tbl_rd_en, 1'b0);
    chk("rst_addrs", {tbl_rd_addr, tbl_wr_addr}, 12'h000);
    chk("rst_wr_data", tbl_wr_data, '0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_skip", skip_count, 16'd0);
    chk("rst_ready", upd_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // init sweep: 64 consecutive zero writes to 0..63
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!(tbl_wr_en === 1'b1 && tbl_wr_addr === 6'(i) && tbl_wr_data === '0)) bad++;
      if (i < 63 && init_done !== 1'b0) bad++;
    end
    chk("sweep_errors", bad, 0);
    @(negedge clk);
    chk("post_sweep_init_done", init_done, 1'b1);
    chk("post_sweep_wr_en", tbl_wr_en, 1'b0);
    chk("post_sweep_busy", busy, 1'b0);

    // basic update from zero
    send(6'd5, 12'hFFF, 1'b1, 1'b1, {12{8'h01}});
    wait_idle("upd5");

    // saturation at both ends and a mixed pattern
    poke(6'd9, {12{8'h7F}});
    send(6'd9, 12'hFFF, 1'b1, 1'b1, {12{8'h7F}});
    wait_idle("sat_hi");
    poke(6'd9, {12{8'h80}});
    send(6'd9, 12'h000, 1'b1, 1'b1, {12{8'h80}});
    wait_idle("sat_lo");
    send(6'd3, 12'h00F, 1'b0, 1'b1, {{8{8'h01}}, {4{8'hFF}}});
    wait_idle("mixed");

    // back-to-back same-entry updates see the previous write
    send(6'd7, 12'hFFF, 1'b0, 1'b1, {12{8'hFF}});
    send(6'd7, 12'hFFF, 1'b0, 1'b1, {12{8'hFE}});
    send(6'd5, 12'hFFF, 1'b1, 1'b1, {12{8'h02}});
    wait_idle("chain");

    // skipped request: counted, no table access, FIFO untouched
    send(6'd12, 12'hABC, 1'b1, 1'b0, '0);
    repeat (6) @(negedge clk);
    chk("skip_count_1", skip_count, 16'd1);
    chk("skip_busy", busy, 1'b0);
    chk("skip_ready", upd_ready, 1'b1);

    // five requests during INIT: FIFO fills at four, all drained in order after init
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_skip", skip_count, 16'd0);
    reset = 1'b0;
    send(6'd10, 12'hFFF, 1'b1, 1'b1, {12{8'h01}});
    send(6'd10, 12'hFFF, 1'b1, 1'b1, {12{8'h02}});
    send(6'd11, 12'h000, 1'b1, 1'b1, {12{8'hFF}});
    send(6'd12, 12'h0F0, 1'b1, 1'b1, {{4{8'hFF}}, {4{8'h01}}, {4{8'hFF}}});
    @(negedge clk);
    chk("full_ready", upd_ready, 1'b0);
    chk("full_init_done", init_done, 1'b0);
    send(6'd10, 12'h000, 1'b0, 1'b1, {12{8'h03}});
    wait_idle("init_fifo");

    // reset during WRITE: write aborted at once, pending request discarded
    send(6'd20, 12'hFFF, 1'b1, 1'b1, {12{8'h01}});
    send(6'd21, 12'hFFF, 1'b1, 1'b1, {12{8'h01}});
    n = 0;
    @(negedge clk);
    while (!(tbl_wr_en && tbl_wr_addr == 6'd20) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wr_seen", {tbl_wr_en, tbl_wr_addr}, {1'b1, 6'd20});
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", tbl_wr_en, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_addr0", {tbl_wr_en, tbl_wr_addr}, {1'b1, 6'd0});
    wait_idle("after_restart");
    repeat (10) @(negedge clk);
    chk("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
